// File: rtl/load_store_unit_pkg.sv
// Shared types for the MEM-stage load/store unit: funct3 width codes, FSM states,
// the result-select code that marks a load, and the access-size decode helper.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LB_SB = 3'b000,
        LH_SH = 3'b001,
        LW_SW = 3'b010,
        LBU   = 3'b100,
        LHU   = 3'b101
    } mem_ctrl_t;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_t;

    // Unsigned variants only exist for loads; any code that is not a known byte or
    // half form falls back to a full word access.
    function automatic access_size_t access_size(input logic [2:0] ctrl, input logic store);
        access_size_t size;
        size = SIZE_WORD;
        if (ctrl == LB_SB || (!store && ctrl == LBU)) begin
            size = SIZE_BYTE;
        end else if (ctrl == LH_SH || (!store && ctrl == LHU)) begin
            size = SIZE_HALF;
        end
        return size;
    endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it according to the funct3 code.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ctrl,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[8*addr_lo +: 8];
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ctrl)
            LB_SB:   data = {{24{lane_byte[7]}}, lane_byte};
            LBU:     data = {24'h000000, lane_byte};
            LH_SH:   data = {{16{lane_half[15]}}, lane_half};
            LHU:     data = {16'h0000, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/ack data-memory handshake with byte lanes, pipeline stall
// and load extension. Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_W_En_M,
    input  logic [1:0]  Result_Src_Sel_M,
    input  logic [2:0]  MEM_Control_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] REG_R_Data2_M,
    output logic        DMEM_Req,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_Addr,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WData,
    input  logic        DMEM_Ack,
    input  logic [31:0] DMEM_RData,
    output logic [31:0] Read_Data_M,
    output logic        Stall_M,
    output logic        Bus_Err_M,
    output logic        Misaligned_M
);

    lsu_state_t   state, state_next;
    access_size_t size;
    logic         access, misalign, stall;
    logic         start_req, ack_hit, timeout_hit, trap_hit;
    logic [7:0]   wait_cnt;
    logic [1:0]   addr_lo;
    logic [2:0]   ctrl_q;
    logic [3:0]   be_next;
    logic [31:0]  wdata_next;
    logic [31:0]  load_value;

    assign access = MEM_W_En_M | (Result_Src_Sel_M == RESULT_SRC_MEM);
    assign size   = access_size(MEM_Control_M, MEM_W_En_M);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (size == SIZE_HALF && ALU_Out_M[0]) ||
                      (size == SIZE_WORD && ALU_Out_M[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Loads always read the whole word; stores replicate the datum into every lane.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (MEM_W_En_M) begin
            case (size)
                SIZE_BYTE: begin
                    be_next    = 4'b0001 << ALU_Out_M[1:0];
                    wdata_next = {4{REG_R_Data2_M[7:0]}};
                end
                SIZE_HALF: begin
                    be_next    = ALU_Out_M[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{REG_R_Data2_M[15:0]}};
                end
                default: wdata_next = REG_R_Data2_M;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        start_req   = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        trap_hit    = 1'b0;
        case (state)
            IDLE: begin
                stall = access;
                if (access) begin
                    if (misalign) begin
                        trap_hit   = 1'b1;
                        state_next = DONE;
                    end else begin
                        start_req  = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // An Ack arriving on the last allowed cycle still completes normally.
                if (DMEM_Ack) begin
                    ack_hit    = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == 8'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Stall_M = stall & RST;

    load_extend u_extend (
        .rdata   (DMEM_RData),
        .addr_lo (addr_lo),
        .ctrl    (ctrl_q),
        .data    (load_value)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DMEM_Req    <= 1'b0;
            DMEM_WE     <= 1'b0;
            DMEM_Addr   <= '0;
            DMEM_BE     <= '0;
            DMEM_WData  <= '0;
            Read_Data_M <= '0;
            Bus_Err_M   <= 1'b0;
            wait_cnt    <= '0;
            addr_lo     <= '0;
            ctrl_q      <= '0;
        end else begin
            Bus_Err_M <= timeout_hit;
            wait_cnt  <= (state == BUSY) ? wait_cnt + 8'd1 : 8'd0;
            if (start_req) begin
                DMEM_Req   <= 1'b1;
                DMEM_WE    <= MEM_W_En_M;
                DMEM_Addr  <= {ALU_Out_M[31:2], 2'b00};
                DMEM_BE    <= be_next;
                DMEM_WData <= wdata_next;
                addr_lo    <= ALU_Out_M[1:0];
                ctrl_q     <= MEM_Control_M;
            end
            if (ack_hit) begin
                DMEM_Req <= 1'b0;
                if (!DMEM_WE) begin
                    Read_Data_M <= load_value;
                end
            end
            if (timeout_hit || trap_hit) begin
                DMEM_Req    <= 1'b0;
                Read_Data_M <= '0;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Misaligned_M <= 1'b0;
        end else begin
            Misaligned_M <= trap_hit;
        end
    end
`else
    assign Misaligned_M = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory model predicts every
// transaction, a responder plays the data memory, and a monitor checks each completion.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TIMEOUT = 4;

    logic        CLK;
    logic        RST;
    logic        MEM_W_En_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [2:0]  MEM_Control_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] REG_R_Data2_M;
    logic        DMEM_Req;
    logic        DMEM_WE;
    logic [31:0] DMEM_Addr;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_WData;
    logic        DMEM_Ack;
    logic [31:0] DMEM_RData;
    logic [31:0] Read_Data_M;
    logic        Stall_M;
    logic        Bus_Err_M;
    logic        Misaligned_M;

    load_store_unit #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .MEM_W_En_M       (MEM_W_En_M),
        .Result_Src_Sel_M (Result_Src_Sel_M),
        .MEM_Control_M    (MEM_Control_M),
        .ALU_Out_M        (ALU_Out_M),
        .REG_R_Data2_M    (REG_R_Data2_M),
        .DMEM_Req         (DMEM_Req),
        .DMEM_WE          (DMEM_WE),
        .DMEM_Addr        (DMEM_Addr),
        .DMEM_BE          (DMEM_BE),
        .DMEM_WData       (DMEM_WData),
        .DMEM_Ack         (DMEM_Ack),
        .DMEM_RData       (DMEM_RData),
        .Read_Data_M      (Read_Data_M),
        .Stall_M          (Stall_M),
        .Bus_Err_M        (Bus_Err_M),
        .Misaligned_M     (Misaligned_M)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bus_err;
        logic        mis;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    int          delay_q[$];
    logic [7:0]  model_mem [1024];
    logic [7:0]  bus_mem [1024];
    logic [31:0] last_read;
    int          checks;
    int          errors;
    logic        force_ack;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic finish_bench();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic int model_size(input logic st, input logic [2:0] c);
        if (st) return (c == 3'b000) ? 1 : (c == 3'b001) ? 2 : 4;
        return (c == 3'b000 || c == 3'b100) ? 1 : (c == 3'b001 || c == 3'b101) ? 2 : 4;
    endfunction

    // Predict one instruction from the byte-level memory model, then hold it in MEM until done.
    task automatic apply_stimulus(input logic st, input logic [2:0] c, input logic [31:0] a,
                                  input logic [31:0] d, input int delay);
        exp_t        e;
        int          n;
        logic [31:0] base;
        logic [31:0] r;
        logic        trap;
        bit          done;
        n    = model_size(st, c);
        base = a & ~(32'(n - 1));
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
        e.req     = !trap;
        e.we      = st;
        e.addr    = a & 32'hFFFF_FFFC;
        e.be      = st ? 4'b0000 : 4'b1111;
        e.wdata   = '0;
        e.bus_err = 1'b0;
        e.mis     = 1'b0;
        if (st) begin
            for (int i = 0; i < n; i++) e.be[int'(base[1:0]) + i] = 1'b1;
            for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = d[8*(k % n) +: 8];
        end
        if (trap) begin
            e.mis = 1'b1; e.stall = 1; last_read = '0;
        end else if (delay < 0) begin
            e.bus_err = 1'b1; e.stall = 1 + TIMEOUT; last_read = '0;
        end else begin
            e.stall = delay + 2;
            if (st) begin
                for (int i = 0; i < n; i++) model_mem[10'(base + 32'(i))] = d[8*i +: 8];
            end else begin
                r = '0;
                for (int i = 0; i < n; i++) r[8*i +: 8] = model_mem[10'(base + 32'(i))];
                if ((c == 3'b000 || c == 3'b001) && n < 4 && r[8*n-1])
                    for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
                last_read = r;
            end
        end
        e.rdata = last_read;
        exp_q.push_back(e);
        if (e.req) delay_q.push_back(delay);
        @(posedge CLK); #1;
        MEM_W_En_M       = st;
        Result_Src_Sel_M = st ? 2'b00 : RESULT_SRC_MEM;
        MEM_Control_M    = c;
        ALU_Out_M        = a;
        REG_R_Data2_M    = d;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge CLK);
            if (!Stall_M) done = 1'b1;
        end
        if (!done) begin
            errors++;
            $display("[TB] FAIL stall_release: Stall_M still 1 after 30 cycles, want 0");
            finish_bench();
        end
    endtask

    task automatic apply_bubble();
        @(posedge CLK); #1;
        MEM_W_En_M       = 1'b0;
        Result_Src_Sel_M = 2'b10;
        MEM_Control_M    = 3'($urandom);
        ALU_Out_M        = $urandom;
        REG_R_Data2_M    = $urandom;
        @(negedge CLK);
        check_output("bubble_stall", 32'(Stall_M), 32'd0);
    endtask

    // Data-memory responder: acks after the queued delay, otherwise throws stray acks.
    initial begin : responder
        bit          active;
        int          wcnt;
        logic [9:0]  w;
        DMEM_Ack   = 1'b0;
        DMEM_RData = '0;
        active     = 1'b0;
        wcnt       = -1;
        forever begin
            @(negedge CLK);
            DMEM_Ack = 1'b0;
            if (DMEM_Req && RST) begin
                if (!active) begin
                    active = 1'b1;
                    checks++;
                    if (delay_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_req: got request at %h, want none", DMEM_Addr);
                        wcnt = -1;
                    end else begin
                        wcnt = delay_q.pop_front();
                    end
                end
                if (wcnt == 0) begin
                    w          = DMEM_Addr[9:0];
                    DMEM_Ack   = 1'b1;
                    DMEM_RData = {bus_mem[w + 10'd3], bus_mem[w + 10'd2], bus_mem[w + 10'd1], bus_mem[w]};
                    if (DMEM_WE)
                        for (int k = 0; k < 4; k++)
                            if (DMEM_BE[k]) bus_mem[w + 10'(k)] = DMEM_WData[8*k +: 8];
                    wcnt = -1;
                end else if (wcnt > 0) begin
                    wcnt--;
                end
            end else begin
                active = 1'b0;
                if (force_ack || $urandom_range(3) == 0) begin
                    DMEM_Ack   = 1'b1;
                    DMEM_RData = $urandom;
                    force_ack  = 1'b0;
                end
            end
        end
    end

    // Monitor: a falling Stall_M marks DONE; pop the scoreboard and compare there.
    initial begin : monitor
        exp_t        e;
        logic        prev_stall, prev_req, seen_req;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        int          stall_cnt;
        prev_stall = 1'b0; prev_req = 1'b0; seen_req = 1'b0; stall_cnt = 0;
        cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev_stall = 1'b0; prev_req = 1'b0; seen_req = 1'b0; stall_cnt = 0;
            end else begin
                if (DMEM_Req && !prev_req) begin
                    seen_req = 1'b1; cap_we = DMEM_WE; cap_addr = DMEM_Addr;
                    cap_be = DMEM_BE; cap_wdata = DMEM_WData;
                end else if (DMEM_Req) begin
                    check_output("req_hold", {DMEM_Addr[31:2], DMEM_BE[1:0]} ^ {DMEM_WData[31:1], DMEM_WE},
                                 {cap_addr[31:2], cap_be[1:0]} ^ {cap_wdata[31:1], cap_we});
                end
                if (Stall_M) stall_cnt++;
                if (prev_stall && !Stall_M) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_done: got completion, want none");
                    end else begin
                        e = exp_q.pop_front();
                        check_output("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        check_output("req_seen", 32'(seen_req), 32'(e.req));
                        if (e.req && seen_req) begin
                            check_output("addr", cap_addr, e.addr);
                            check_output("we", 32'(cap_we), 32'(e.we));
                            check_output("be", 32'(cap_be), 32'(e.be));
                            if (e.we) check_output("wdata", cap_wdata, e.wdata);
                        end
                        check_output("read_data", Read_Data_M, e.rdata);
                        check_output("bus_err", 32'(Bus_Err_M), 32'(e.bus_err));
                        check_output("misaligned", 32'(Misaligned_M), 32'(e.mis));
                        check_output("req_done", 32'(DMEM_Req), 32'd0);
                    end
                    stall_cnt = 0;
                    seen_req  = 1'b0;
                end else begin
                    check_output("flags_idle", {30'd0, Bus_Err_M, Misaligned_M}, 32'd0);
                end
                prev_stall = Stall_M;
                prev_req   = DMEM_Req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        finish_bench();
    end

    initial begin : stimulus
        bit          st;
        int          dly;
        checks = 0; errors = 0; force_ack = 1'b0; last_read = '0;
        for (int i = 0; i < 1024; i++) begin
            model_mem[i] = 8'($urandom);
            bus_mem[i]   = model_mem[i];
        end
        {model_mem[259], model_mem[258], model_mem[257], model_mem[256]} = 32'h80FF0000;
        {model_mem[515], model_mem[514], model_mem[513], model_mem[512]} = 32'hBEEF0000;
        for (int i = 256; i < 260; i++) bus_mem[i] = model_mem[i];
        for (int i = 512; i < 516; i++) bus_mem[i] = model_mem[i];

        RST = 1'b0;
        MEM_W_En_M = 1'b1; Result_Src_Sel_M = 2'b00; MEM_Control_M = 3'b010;
        ALU_Out_M = 32'h100; REG_R_Data2_M = 32'h0;
        repeat (2) @(negedge CLK);
        check_output("rst_req", 32'(DMEM_Req), 32'd0);
        check_output("rst_stall", 32'(Stall_M), 32'd0);
        check_output("rst_read_data", Read_Data_M, 32'd0);
        check_output("rst_outs", {DMEM_Addr[31:6], DMEM_BE, DMEM_WE, Bus_Err_M} | DMEM_WData, 32'd0);
        MEM_W_En_M = 1'b0;
        #1 RST = 1'b1;
        $display("[TB] reset released, starting directed transactions");

        apply_stimulus(1'b0, 3'b000, 32'h103, 32'h0, 0);
        apply_stimulus(1'b0, 3'b100, 32'h103, 32'h0, 2);
        apply_stimulus(1'b0, 3'b101, 32'h202, 32'h0, 1);
        apply_stimulus(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0);
        apply_stimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1);
        apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0, -1);
        apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0, 3);
        apply_stimulus(1'b1, 3'b010, 32'h101, 32'h5A5A0F0F, 0);
        apply_stimulus(1'b0, 3'b001, 32'h203, 32'h0, 0);
        apply_bubble();

        $display("[TB] starting randomized transactions");
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(3) == 0) begin
                apply_bubble();
            end else begin
                st  = 1'($urandom);
                dly = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(3));
                apply_stimulus(st, 3'($urandom), $urandom, $urandom, dly);
            end
        end
        apply_bubble();
        apply_bubble();
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset during an outstanding request");
        delay_q.push_back(-1);
        @(posedge CLK); #1;
        MEM_W_En_M = 1'b0; Result_Src_Sel_M = RESULT_SRC_MEM;
        MEM_Control_M = 3'b010; ALU_Out_M = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        check_output("busy_req", 32'(DMEM_Req), 32'd1);
        #1 RST = 1'b0;
        #1;
        check_output("abort_req", 32'(DMEM_Req), 32'd0);
        check_output("abort_stall", 32'(Stall_M), 32'd0);
        check_output("abort_read_data", Read_Data_M, 32'd0);
        MEM_W_En_M = 1'b0; Result_Src_Sel_M = 2'b10;
        @(negedge CLK);
        #1 RST = 1'b1;
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_output("post_rst_stall", 32'(Stall_M), 32'd0);
            check_output("post_rst_req", 32'(DMEM_Req), 32'd0);
            check_output("post_rst_read_data", Read_Data_M, 32'd0);
        end
        check_output("post_rst_scoreboard", 32'(exp_q.size() + delay_q.size()), 32'd0);
        finish_bench();
    end

endmodule
